// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser driving the VGA adapter plot port, one pixel per clock.
// Draws outline or filled circles at any centre/radius with screen-edge clipping.
module circle_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          fill,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  input  logic [XW-1:0] radius,
  input  logic [CW-1:0] colour,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  localparam int OW  = XW + 1;
  localparam int CRW = XW + 2;
  localparam int PW  = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [CRW-1:0] C_ONE = CRW'(1);
  localparam logic signed [PW-1:0]  X_LIM = PW'(SCREEN_W);
  localparam logic signed [PW-1:0]  Y_LIM = PW'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PLOT,
    S_STEP,
    S_DONE
  } state_t;

  state_t state, nxt_state;

  logic          lat_fill;
  logic [XW-1:0] lat_cx;
  logic [YW-1:0] lat_cy;
  logic [XW-1:0] lat_r;
  logic [CW-1:0] lat_col;

  logic signed [OW-1:0]  ox, oy, dx, nxt_ox, nxt_oy, nxt_dx, step_oy, span_half;
  logic signed [CRW-1:0] crit, nxt_crit, oy_c, diff_c;
  logic [2:0]            seg, nxt_seg;

  logic signed [PW-1:0] cx_p, cy_p, n_ox_p, n_oy_p, n_dx_p, off_x, off_y, px, py;
  logic                 on_screen;

  // seg is the octant (outline) or span (fill, low 2 bits); dx walks each span
  always_comb begin : next_logic
    nxt_state = state;
    nxt_ox    = ox;
    nxt_oy    = oy;
    nxt_dx    = dx;
    nxt_crit  = crit;
    nxt_seg   = seg;
    step_oy   = oy + OW'(1);
    span_half = seg[1] ? oy : ox;
    oy_c      = CRW'(step_oy);
    diff_c    = '0;
    case (state)
      S_IDLE: if (start) nxt_state = S_INIT;
      S_INIT: begin
        nxt_ox    = {1'b0, lat_r};
        nxt_oy    = '0;
        nxt_crit  = C_ONE - {2'b00, lat_r};
        nxt_seg   = '0;
        nxt_dx    = -$signed({1'b0, lat_r});
        nxt_state = S_PLOT;
      end
      S_PLOT: begin
        if (!lat_fill) begin
          if (seg == 3'd7) nxt_state = S_STEP;
          else             nxt_seg   = seg + 3'd1;
        end else if (dx == span_half) begin
          if (seg[1:0] == 2'd3) begin
            nxt_state = S_STEP;
          end else begin
            nxt_seg = seg + 3'd1;
            nxt_dx  = -(nxt_seg[1] ? oy : ox);
          end
        end else begin
          nxt_dx = dx + OW'(1);
        end
      end
      S_STEP: begin
        nxt_oy = step_oy;
        if (crit[CRW-1] || crit == '0) begin
          nxt_crit = crit + oy_c + oy_c + C_ONE;
        end else begin
          nxt_ox   = ox - OW'(1);
          diff_c   = oy_c - CRW'(nxt_ox);
          nxt_crit = crit + diff_c + diff_c + C_ONE;
        end
        nxt_seg   = '0;
        nxt_dx    = -nxt_ox;
        nxt_state = (step_oy > nxt_ox) ? S_DONE : S_PLOT;
      end
      S_DONE: if (!start) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Pixel is formed from next-cycle iterator values so the registered outputs line up with PLOT
  always_comb begin : pixel_logic
    cx_p   = PW'({1'b0, lat_cx});
    cy_p   = PW'({1'b0, lat_cy});
    n_ox_p = PW'(nxt_ox);
    n_oy_p = PW'(nxt_oy);
    n_dx_p = PW'(nxt_dx);
    off_x  = '0;
    off_y  = '0;
    if (!lat_fill) begin
      case (nxt_seg)
        3'd0: begin off_x =  n_ox_p; off_y =  n_oy_p; end
        3'd1: begin off_x =  n_oy_p; off_y =  n_ox_p; end
        3'd2: begin off_x = -n_ox_p; off_y =  n_oy_p; end
        3'd3: begin off_x = -n_oy_p; off_y =  n_ox_p; end
        3'd4: begin off_x = -n_ox_p; off_y = -n_oy_p; end
        3'd5: begin off_x = -n_oy_p; off_y = -n_ox_p; end
        3'd6: begin off_x =  n_ox_p; off_y = -n_oy_p; end
        default: begin off_x = n_oy_p; off_y = -n_ox_p; end
      endcase
    end else begin
      off_x = n_dx_p;
      case (nxt_seg[1:0])
        2'd0:    off_y =  n_oy_p;
        2'd1:    off_y = -n_oy_p;
        2'd2:    off_y =  n_ox_p;
        default: off_y = -n_ox_p;
      endcase
    end
    px        = cx_p + off_x;
    py        = cy_p + off_y;
    on_screen = !px[PW-1] && (px < X_LIM) && !py[PW-1] && (py < Y_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ox         <= '0;
      oy         <= '0;
      dx         <= '0;
      crit       <= '0;
      seg        <= '0;
      lat_fill   <= 1'b0;
      lat_cx     <= '0;
      lat_cy     <= '0;
      lat_r      <= '0;
      lat_col    <= '0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state <= nxt_state;
      ox    <= nxt_ox;
      oy    <= nxt_oy;
      dx    <= nxt_dx;
      crit  <= nxt_crit;
      seg   <= nxt_seg;
      if (state == S_IDLE && start) begin
        lat_fill <= fill;
        lat_cx   <= centre_x;
        lat_cy   <= centre_y;
        lat_r    <= radius;
        lat_col  <= colour;
      end
      done     <= (nxt_state == S_DONE);
      vga_plot <= (nxt_state == S_PLOT) && on_screen;
      if (nxt_state == S_PLOT) begin
        vga_x      <= px[XW-1:0];
        vga_y      <= py[YW-1:0];
        vga_colour <= lat_col;
      end
    end
  end

endmodule
